// File: rtl/rca_seq_pkg.sv
// rtl/rca_seq_pkg.sv - shared FSM state type and operation codes for rca_word_seq
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/rca_word_seq_if.sv
// rtl/rca_word_seq_if.sv - request/result handshake bundle for rca_word_seq
interface rca_word_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );

endinterface

// File: rtl/nibble_add.sv
// rtl/nibble_add.sv - 4-bit combinational ripple-carry adder slice
module nibble_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/rca_word_seq.sv
// rtl/rca_word_seq.sv - word add/subtract computed one nibble per cycle through a
// single shared ripple slice, LSB nibble first, with a valid/ready result hold.
module rca_word_seq
    import rca_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    rca_word_seq_if.slave bus
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       bx_q, bx_d;
    logic [W-1:0]       result_q, result_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [3:0]         slice_a, slice_b, slice_sum;
    logic               slice_cout;
    logic               last_nib;

    assign slice_a  = a_q[4*idx_q +: 4];
    assign slice_b  = bx_q[4*idx_q +: 4];
    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

    nibble_add u_nibble_add (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (last_nib)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;

    // Subtract is a + ~b + 1: b is inverted at capture and the +1 rides in as the first carry.
    always_comb begin
        a_d      = a_q;
        bx_d     = bx_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    bx_d    = bus.b ^ {W{bus.op}};
                    carry_d = (bus.op == OP_SUB);
                    idx_d   = '0;
                end
            end
            RUN: begin
                result_d[4*idx_q +: 4] = slice_sum;
                carry_d                = slice_cout;
                if (last_nib) begin
                    cout_d = slice_cout;
                    ovf_d  = (a_q[W-1] == bx_q[W-1]) && (slice_sum[3] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            bx_q     <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            bx_q     <= bx_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_rca_word_seq.sv
// tb/tb_rca_word_seq.sv - directed self-checking bench for rca_word_seq
module tb_rca_word_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rca_word_seq_if #(.NIBBLES(NIB)) bus ();

    rca_word_seq #(.NIBBLES(NIB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_n   = 0;
    int ov_cyc = 0;
    int hs_cyc[$];
    logic [W+1:0] out_q[$];

    always @(posedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) begin
            hs_cyc.push_back(cyc);
            hs_n++;
        end
        if (!rst && bus.out_valid && bus.out_ready)
            out_q.push_back({bus.cout, bus.ovf, bus.result});
        if (bus.out_valid)
            ov_cyc++;
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic top, input logic [W-1:0] exp_r,
                            input logic exp_c, input logic exp_o);
        int n;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_;
        bus.op       = top;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, ".latency"}, 32'(n), NIB);
        check({tag, ".result"}, 32'(bus.result), 32'(exp_r));
        check({tag, ".cout"}, 32'(bus.cout), 32'(exp_c));
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(exp_o));
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, ".idle_ov"}, 32'(bus.out_valid), 0);
        check({tag, ".idle_rdy"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        int hs0;
        int ov0;
        int hsb;
        int obase;
        int n;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst.out_valid", 32'(bus.out_valid), 0);
        check("rst.result", 32'(bus.result), 0);
        check("rst.cout", 32'(bus.cout), 0);
        check("rst.ovf", 32'(bus.ovf), 0);

        // First handshake right after reset release
        start_op("add1", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        consume("add1");
        start_op("sub1", 16'h0007, 16'h000E, 1'b1, 16'hFFF9, 1'b0, 1'b0);
        consume("sub1");
        start_op("sub2", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        consume("sub2");
        start_op("ovf1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        consume("ovf1");
        start_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        consume("wrap");

        // Backpressure with stray requests while DONE
        start_op("bp", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);
        hs0 = hs_n;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'h5555 + 16'(i);
            bus.b        = 16'h1111;
            bus.op       = 1'(i);
            tick();
            check("bp.result", 32'(bus.result), 32'h1000);
            check("bp.cout", 32'(bus.cout), 0);
            check("bp.ovf", 32'(bus.ovf), 0);
            check("bp.out_valid", 32'(bus.out_valid), 1);
            check("bp.in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        check("bp.nocapture", 32'(hs_n), 32'(hs0));
        consume("bp");
        check("bp.nocapture2", 32'(hs_n), 32'(hs0));
        start_op("bp_next", 16'h0A0A, 16'h0505, 1'b1, 16'h0505, 1'b1, 1'b0);
        consume("bp_next");

        // Abort in RUN
        bus.in_valid = 1'b1;
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.op       = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ov0 = ov_cyc;
        check("abort.out_valid", 32'(bus.out_valid), 0);
        check("abort.result", 32'(bus.result), 0);
        check("abort.in_ready", 32'(bus.in_ready), 1);
        repeat (8) tick();
        check("abort.no_pulse", 32'(ov_cyc), 32'(ov0));
        start_op("post_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        consume("post_abort");

        // Back-to-back with out_ready tied high
        bus.out_ready = 1'b1;
        hsb   = hs_n;
        obase = out_q.size();
        bus.in_valid = 1'b1;
        bus.a  = 16'h0100;
        bus.b  = 16'h0023;
        bus.op = 1'b0;
        n = 0;
        while (hs_n == hsb && n < 20) begin
            tick();
            n++;
        end
        bus.a  = 16'h0050;
        bus.b  = 16'h0060;
        bus.op = 1'b1;
        n = 0;
        while (hs_n == hsb + 1 && n < 20) begin
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        check("b2b.hs_count", 32'(hs_n), 32'(hsb + 2));
        if (hs_n == hsb + 2)
            check("b2b.spacing", 32'(hs_cyc[hsb+1] - hs_cyc[hsb]), NIB + 2);
        n = 0;
        while (out_q.size() < obase + 2 && n < 30) begin
            tick();
            n++;
        end
        bus.out_ready = 1'b0;
        check("b2b.out_count", 32'(out_q.size()), 32'(obase + 2));
        if (out_q.size() >= obase + 2) begin
            check("b2b.first", 32'(out_q[obase]), 32'h0_0123);
            check("b2b.second", 32'(out_q[obase+1]), 32'h0_FFF0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
